pwm_wave_gen: RTL

Programmable PWM/square-wave generator with an Avalon-MM slave register port, instantiated inside nios_system as the custom component that drives the exported `out_wave` conduit. The Nios II processor writes period, duty and control registers. The block runs a free-running period counter and produces a glitch-free registered output. Period/duty changes are double-buffered and take effect only on a period boundary.

---
 rtl/pwm_wave_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pwm_wave_gen.sv
// rtl/pwm_wave_gen.sv - Avalon-MM programmable PWM generator with double-buffered period/duty
// Active period/duty only change on a period wrap (or while idle) so out_wave never glitches.
module pwm_wave_gen #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        out_wave
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             inv_q, inv_d;
    logic [CNT_W-1:0] per_p_q, per_p_d;
    logic [CNT_W-1:0] duty_p_q, duty_p_d;
    logic [CNT_W-1:0] per_a_q, per_a_d;
    logic [CNT_W-1:0] duty_a_q, duty_a_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wraps_q, wraps_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             out_q, out_d;

    logic             run, wrap, raw;
    logic [CNT_W-1:0] wdata_cnt;

    assign wdata_cnt    = avs_writedata[CNT_W-1:0];
    assign avs_readdata = rdata_q;
    assign out_wave     = out_q;

    always_comb begin
        state_d  = state_q;
        inv_d    = inv_q;
        per_p_d  = per_p_q;
        duty_p_d = duty_p_q;
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        wraps_d  = wraps_q;
        rdata_d  = rdata_q;

        run   = (state_q == RUN) && (per_a_q != '0);
        wrap  = run && (cnt_q == per_a_q - ONE);
        raw   = run && (cnt_q < duty_a_q);
        out_d = raw ^ inv_q;

        if (state_q == RUN) begin
            if (per_a_q == '0) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d   = '0;
                wraps_d = wraps_q + 16'd1;
                if (pend_q) begin
                    per_a_d  = per_p_q;
                    duty_a_d = duty_p_q;
                    pend_d   = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = '0;
        end

        // Register writes come after the wrap logic so a same-edge write re-arms pend.
        if (avs_write) begin
            case (avs_address)
                2'd0: begin
                    inv_d = avs_writedata[1];
                    if (avs_writedata[0] && state_q == IDLE) begin
                        state_d  = RUN;
                        per_a_d  = per_p_q;
                        duty_a_d = duty_p_q;
                        cnt_d    = '0;
                        pend_d   = 1'b0;
                    end else if (!avs_writedata[0] && state_q == RUN) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                2'd1: begin
                    per_p_d = wdata_cnt;
                    if (state_q == IDLE) per_a_d = wdata_cnt;
                    else                 pend_d  = 1'b1;
                end
                2'd2: begin
                    duty_p_d = wdata_cnt;
                    if (state_q == IDLE) duty_a_d = wdata_cnt;
                    else                 pend_d   = 1'b1;
                end
                default: ;
            endcase
        end

        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = {30'd0, inv_q, state_q == RUN};
                2'd1:    rdata_d = 32'(per_p_q);
                2'd2:    rdata_d = 32'(duty_p_q);
                default: rdata_d = {wraps_q, 14'd0, pend_q, run};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            inv_q    <= 1'b0;
            per_p_q  <= '0;
            duty_p_q <= '0;
            per_a_q  <= '0;
            duty_a_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            wraps_q  <= '0;
            rdata_q  <= '0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inv_q    <= inv_d;
            per_p_q  <= per_p_d;
            duty_p_q <= duty_p_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wraps_q  <= wraps_d;
            rdata_q  <= rdata_d;
            out_q    <= out_d;
        end
    end
endmodule
